// File: rtl/spi_slave_port.sv
// ---------------------------------------------------------------------------
// spi_slave_port
//
// Word-oriented SPI slave (mode 0, MSB first) running entirely on the system
// clock. SCLK, CS and MOSI are oversampled through synchronizer chains. Edges
// are detected after the chain and act SYNC_STAGES+1 clk after the pin edge.
// One WIDTH-bit word is exchanged per CS window.
//
// Ports
//   clk       system clock, all state on its rising edge
//   rst       asynchronous, active-low reset
//   SPI_SCLK  serial clock from master (idle low)
//   SPI_CS    chip select from master (active low)
//   SPI_MOSI  serial data from master
//   SPI_MISO  serial data to master (driven low when not shifting)
//   tx_data   word to send on the next transfer
//   tx_wr     1-cycle strobe: latch tx_data into the single-entry TX buffer
//   tx_full   TX buffer holds a word not yet sent
//   rx_data   last complete word received, held until the next one
//   rx_valid  1-cycle pulse: rx_data updated
//   abort     1-cycle pulse: CS released before WIDTH bits were clocked
// ---------------------------------------------------------------------------
module spi_slave_port #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SPI_SCLK,
    input  logic             SPI_CS,
    input  logic             SPI_MOSI,
    output logic             SPI_MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_full,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             abort
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Synchronizer chains: bit 0 is the first flop, bit SYNC_STAGES-1 the last.
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_prev_reg;
    logic                   cs_prev_reg;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shift_tx_reg;
    // The MSB of the receive word is never needed from the shifter itself:
    // the completed word is assembled from these bits plus the final MOSI bit.
    logic [WIDTH-2:0] rx_shift_reg;
    logic [WIDTH-1:0] tx_buf_reg;
    logic             tx_full_reg;
    logic [WIDTH-1:0] rx_data_reg;
    logic             rx_valid_reg;
    logic             abort_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
            cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_prev_reg;
    assign cs_fall   = ~cs_sync_reg[SYNC_STAGES-1] & cs_prev_reg;
    assign cs_rise   = cs_sync_reg[SYNC_STAGES-1] & ~cs_prev_reg;
    // MOSI goes through the same number of flops as SCLK, so at the acting
    // SCLK edge this is the bit the master presented before its rise.
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            shift_tx_reg <= '0;
            rx_shift_reg <= '0;
            tx_buf_reg   <= '0;
            tx_full_reg  <= 1'b0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            abort_reg    <= 1'b0;

            // Single-entry buffer: the last write wins. The CS-fall branch
            // below may clear tx_full, but only when no write is concurrent.
            if (tx_wr) begin
                tx_buf_reg  <= tx_data;
                tx_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shift_tx_reg <= tx_full_reg ? tx_buf_reg : IDLE_WORD;
                        if (!tx_wr) begin
                            tx_full_reg <= 1'b0;
                        end
                        count_reg <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Early release: discard the partial word. Clearing
                        // the TX shifter keeps MISO low while idle.
                        abort_reg    <= 1'b1;
                        shift_tx_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[WIDTH-3:0], mosi_s};
                        shift_tx_reg <= {shift_tx_reg[WIDTH-2:0], 1'b0};
                        count_reg    <= count_reg + 1'b1;
                        if (count_reg == CW'(WIDTH - 1)) begin
                            rx_data_reg  <= {rx_shift_reg, mosi_s};
                            rx_valid_reg <= 1'b1;
                            state_reg    <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // All WIDTH bits are shifted out, so the TX shifter is
                    // already zero and MISO stays low through extra clocks.
                    if (cs_rise) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    shift_tx_reg <= '0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign SPI_MISO = shift_tx_reg[WIDTH-1];
    assign tx_full  = tx_full_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign abort    = abort_reg;

endmodule

// File: tb/tb_spi_slave_port.sv
// ---------------------------------------------------------------------------
// Bench for spi_slave_port: a mode-0 master model drives directed words, the
// expected receive-side events are queued at issue time and a separate
// monitor pops and compares them whenever rx_valid or abort pulses.
// ---------------------------------------------------------------------------
module tb_spi_slave_port;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_wr;
    logic         tx_full;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         abort;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           is_abort;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic [63:0] got;
    logic        txf_at_start;

    spi_slave_port #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .IDLE_WORD  (32'h00000000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SPI_SCLK(sclk),
        .SPI_CS  (cs),
        .SPI_MOSI(mosi),
        .SPI_MISO(miso),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_full (tx_full),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .abort   (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_rx(input logic [W-1:0] d);
        exp_t e;
        e.is_abort = 1'b0;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic push_abort(input logic [W-1:0] held);
        exp_t e;
        e.is_abort = 1'b1;
        e.data     = held;
        exp_q.push_back(e);
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled at each rise.
    // SCLK period is 8 clk (4 high, 4 low). Returns the MISO bits in got.
    task automatic transfer(input logic [W-1:0] word, input int nbits,
                            input bit raise_cs, input int gap);
        got = '0;
        @(negedge clk);
        cs   = 1'b0;
        sclk = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < W) ? word[W-1-i] : 1'b0;
            wait_clk(4);
            if (i == 0) txf_at_start = tx_full;
            got  = {got[62:0], miso};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        if (raise_cs) begin
            cs = 1'b1;
            wait_clk(gap);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid && abort) check("pulse_overlap", 64'd1, 64'd0);
            if (rx_valid || abort) begin
                if (exp_q.size() == 0) begin
                    check(rx_valid ? "unexpected_rx_valid" : "unexpected_abort", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {63'd0, abort}, {63'd0, e.is_abort});
                    check(e.is_abort ? "rx_data_held" : "rx_data", {32'd0, rx_data}, {32'd0, e.data});
                end
            end
        end
    end

    // Watchdog
    initial begin
        wait_clk(50000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_wr = 1'b0; txf_at_start = 1'b0;
        wait_clk(4);
        check("reset_miso",     {63'd0, miso},     64'd0);
        check("reset_tx_full",  {63'd0, tx_full},  64'd0);
        check("reset_rx_data",  {32'd0, rx_data},  64'd0);
        check("reset_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("reset_abort",    {63'd0, abort},    64'd0);
        rst = 1'b1;
        wait_clk(4);

        // 1: buffered word out, 0x12345678 in
        tx_write(32'hFEDCBA98);
        check("t1_tx_full_before", {63'd0, tx_full}, 64'd1);
        push_rx(32'h12345678);
        transfer(32'h12345678, 32, 1'b1, 10);
        check("t1_tx_full_at_cs", {63'd0, txf_at_start}, 64'd0);
        check("t1_miso_word", got, 64'h00000000FEDCBA98);

        // 2: nothing buffered -> idle word
        push_rx(32'hA5A5A5A5);
        transfer(32'hA5A5A5A5, 32, 1'b1, 10);
        check("t2_miso_idle", got, 64'd0);

        // 3: abort after 13 rises, then clean transfer
        push_abort(32'hA5A5A5A5);
        transfer(32'h0F0F0F0F, 13, 1'b1, 10);
        push_rx(32'h0000FFFF);
        transfer(32'h0000FFFF, 32, 1'b1, 10);
        check("t3_miso_idle", got, 64'd0);

        // 4: last write wins; mid-transfer write held for next word
        tx_write(32'h11111111);
        tx_write(32'h22222222);
        push_rx(32'h3C3C3C3C);
        fork
            transfer(32'h3C3C3C3C, 32, 1'b1, 10);
            begin wait_clk(100); tx_write(32'h33333333); end
        join
        check("t4_miso_last_wins", got, 64'h0000000022222222);
        check("t4_tx_full_after", {63'd0, tx_full}, 64'd1);
        push_rx(32'h00000001);
        transfer(32'h00000001, 32, 1'b1, 10);
        check("t4_miso_next", got, 64'h0000000033333333);

        // 5: reset after 20 bits
        tx_write(32'h0BADF00D);
        transfer(32'hCAFEF00D, 20, 1'b0, 0);
        tx_write(32'h55555555);
        check("t5_tx_full_pre_rst", {63'd0, tx_full}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_miso",    {63'd0, miso},    64'd0);
        check("t5_rst_tx_full", {63'd0, tx_full}, 64'd0);
        check("t5_rst_rx_data", {32'd0, rx_data}, 64'd0);
        cs = 1'b1; sclk = 1'b0;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(5);
        check("t5_idle_miso", {63'd0, miso}, 64'd0);
        push_rx(32'hDEADBEEF);
        transfer(32'hDEADBEEF, 32, 1'b1, 10);
        check("t5_miso_idle", got, 64'd0);

        // 6: back-to-back with 4 clk CS-high gap, then 36 rises in one window
        push_rx(32'h13579BDF);
        transfer(32'h13579BDF, 32, 1'b1, 4);
        push_rx(32'h2468ACE0);
        transfer(32'h2468ACE0, 32, 1'b1, 10);
        tx_write(32'hF0000001);
        push_rx(32'h89ABCDEF);
        transfer(32'h89ABCDEF, 36, 1'b1, 10);
        check("t6_miso_36", got, 64'h0000000F00000010);

        wait_clk(20);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
